count_sequencer: RTL and testbench
==================================

# count_sequencer

Command-driven controller for the 4-bit truncated up-down counter (range 2..10) that sits between the testbench/system command source and the counter's control pins. It accepts one command at a time over a valid/ready handshake. For each command it loads a value, steps the counter a programmed number of cycles up or down, or bounces between the range limits. Between commands it freezes the counter by reloading its own count, since the counter has no enable.

## Interface
- No parameters; the range limits and widths are fixed package constants.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 BOUNCE.
- cmd_data  in  4  LOAD: value to load; other ops: step count (0..15).
- count  in  4  counter output, fed back.
- din  out  4  counter load data.
- load  out  1  counter load strobe.
- up_down  out  1  counter direction; 1 = up, 0 = down.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse, coincident with done, for a rejected command.

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset enters IDLE with steps=0, dir=up, done=0, err=0, cmd_ready=1.
- IDLE (hold):
  - Outputs: load=1, din=count, up_down=1.
  - Accepts a command when cmd_valid && cmd_ready.
- Command decode on accept:
  - LOAD with cmd_data in 2..10 -> LOAD.
  - LOAD with cmd_data outside 2..10 -> DONE with err.
  - UP/DOWN/BOUNCE with cmd_data=0 -> DONE, no err, no counter activity.
  - UP/DOWN/BOUNCE with cmd_data>0 -> RUN, steps=cmd_data; dir=up for UP and BOUNCE, down for DOWN.
- LOAD: load=1, din=latched value for one cycle -> DONE.
- RUN:
  - Outputs: load=0, up_down=dir; steps decrements each cycle.
  - Leaves for DONE in the cycle steps reaches 1.
  - UP/DOWN wrap naturally in the counter: 10->2 going up, 2->10 going down. The sequencer does not block the wrap.
- BOUNCE: up_down is derived combinationally from count, so the counter never wraps:
  - count==10 -> down, and dir is updated.
  - count==2 -> up, and dir is updated.
  - otherwise dir is retained.
- DONE: hold outputs as in IDLE; done=1, err as latched -> IDLE.
- count outside 2..10 while RUN: no special handling; the counter's own behaviour applies.

## Timing
- din, load and up_down are combinational from the registered state and count. The counter samples them on the next clock edge.
- cmd_ready, busy, done and err are registered.
- LOAD latency:
  - Accept at edge E0.
  - Counter loads at E1.
  - done high in the cycle after E1.
  - cmd_ready high one cycle later.
- UP/DOWN/BOUNCE latency:
  - Accept at E0; N counter steps at E1..EN.
  - done high in the cycle after EN.
  - Next accept no earlier than edge EN+2.
- Counter is held, never stepped, in IDLE, DONE and LOAD cycles.
- Reset mid-command takes effect immediately, not on an edge:
  - State goes to IDLE, the pending command is discarded, and no done is issued.
  - Outputs go straight to hold values.

## Configuration
- COUNT_SEQ_BOUNCE_EN defined: op 11 runs BOUNCE as above.
- COUNT_SEQ_BOUNCE_EN undefined:
  - op 11 is illegal: accept -> DONE with err=1, no counter activity.
  - Bounce direction logic is removed.

## Structure
- count_seq_pkg holds:
  - op_e enum (LOAD, UP, DOWN, BOUNCE).
  - state_e enum (IDLE, LOAD, RUN, DONE).
  - CNT_MIN=2, CNT_MAX=10, CNT_W=4.
- One sub-module: count_seq_steps, the 4-bit loadable step down-counter with last-step flag.

## Test plan
- Reset, then LOAD 7 -> load=1, din=7 at E1; count=7; done pulses once; err=0; cmd_ready returns high.
- count=8, UP 4 -> count 9,10,2,3 on E1..E4; done in the following cycle; count stays 3 afterwards.
- count=3, DOWN 3 -> count 2,10,9; then held at 9 while IDLE for 10 cycles.
- count=9, BOUNCE 5 (COUNT_SEQ_BOUNCE_EN defined) -> count 10,9,8,7,6; never reaches 2. Without the macro: err=1 and done=1 together, count unchanged.
- LOAD 12 -> err=1 with done; no load strobe to the counter; count unchanged. UP 0 -> done with err=0; count unchanged.
- Assert reset during step 2 of UP 6 -> busy=0 and cmd_ready=1 immediately; no done pulse; the next command is accepted normally.

Source files
------------

// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared enums and range constants for the count sequencer
package count_seq_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MIN = 4'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd10;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_UP     = 2'b01,
        OP_DOWN   = 2'b10,
        OP_BOUNCE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic in_range(input logic [CNT_W-1:0] v);
        return (v >= CNT_MIN) && (v <= CNT_MAX);
    endfunction

endpackage

// File: rtl/count_seq_steps.sv
// rtl/count_seq_steps.sv - loadable step down-counter with last-step flag
module count_seq_steps
    import count_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] steps;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            steps <= '0;
        end else if (load) begin
            steps <= load_val;
        end else if (dec && (steps != '0)) begin
            steps <= steps - CNT_W'(1);
        end
    end

    assign last = (steps == CNT_W'(1));

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - command sequencer for the 2..10 up-down counter; COUNT_SEQ_BOUNCE_EN enables op 11 bounce
module count_sequencer
    import count_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_data,
    input  logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] din,
    output logic             load,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state;
    state_e           dec_state;
    op_e              op;
    logic             accept;
    logic             dec_err;
    logic             dec_dir;
    logic             dir;
    logic             run_dir;
    logic             last;
    logic [CNT_W-1:0] load_val;
`ifdef COUNT_SEQ_BOUNCE_EN
    logic             bounce;
`endif

    assign op     = op_e'(cmd_op);
    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        dec_state = ST_DONE;
        dec_err   = 1'b0;
        dec_dir   = 1'b1;
        case (op)
            OP_LOAD: begin
                if (in_range(cmd_data)) dec_state = ST_LOAD;
                else                    dec_err   = 1'b1;
            end
            OP_UP: begin
                if (cmd_data != '0) dec_state = ST_RUN;
            end
            OP_DOWN: begin
                dec_dir = 1'b0;
                if (cmd_data != '0) dec_state = ST_RUN;
            end
            default: begin
`ifdef COUNT_SEQ_BOUNCE_EN
                if (cmd_data != '0) dec_state = ST_RUN;
`else
                dec_err = 1'b1;
`endif
            end
        endcase
    end

    // Bounce turns around at the limits so the counter never wraps.
`ifdef COUNT_SEQ_BOUNCE_EN
    always_comb begin
        run_dir = dir;
        if (bounce) begin
            if (count == CNT_MAX)      run_dir = 1'b0;
            else if (count == CNT_MIN) run_dir = 1'b1;
        end
    end
`else
    assign run_dir = dir;
`endif

    // The counter has no enable: every non-RUN state reloads its own count.
    always_comb begin
        load    = 1'b1;
        din     = count;
        up_down = 1'b1;
        case (state)
            ST_LOAD: din = load_val;
            ST_RUN: begin
                load    = 1'b0;
                up_down = run_dir;
            end
            default: ;
        endcase
    end

    count_seq_steps u_steps (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .dec      (state == ST_RUN),
        .load_val (cmd_data),
        .last     (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            dir       <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            load_val  <= '0;
`ifdef COUNT_SEQ_BOUNCE_EN
            bounce    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= dec_state;
                        done      <= (dec_state == ST_DONE);
                        err       <= dec_err;
                        dir       <= dec_dir;
                        load_val  <= cmd_data;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef COUNT_SEQ_BOUNCE_EN
                        bounce    <= (op == OP_BOUNCE);
`endif
                    end
                end
                ST_LOAD: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_RUN: begin
                    dir <= run_dir;
                    if (last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer with a behavioural counter; honours COUNT_SEQ_BOUNCE_EN
module tb_count_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [3:0] cnt_q = 4'd5;
    logic       cmd_ready;
    logic [3:0] din;
    logic       load;
    logic       up_down;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct {
        int cnt;
        int err;
        int at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   model_count = 5;
    bit   prev_done = 1'b0;

    count_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .count     (cnt_q),
        .din       (din),
        .load      (load),
        .up_down   (up_down),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Truncated 2..10 up-down counter driven by the sequencer.
    always @(posedge clock) begin
        if (load)          cnt_q <= din;
        else if (up_down)  cnt_q <= (cnt_q >= 4'd10) ? 4'd2 : cnt_q + 4'd1;
        else               cnt_q <= (cnt_q <= 4'd2) ? 4'd10 : cnt_q - 4'd1;
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Final count after a command, from modular / triangle-wave arithmetic.
    function automatic void model(input int op, input int data, input int cur,
                                  output int nc, output int e, output int lat);
        int x;
        nc = cur; e = 0; lat = 0;
        case (op)
            0: if (data >= 2 && data <= 10) begin nc = data; lat = 1; end
               else e = 1;
            1: if (data != 0) begin nc = (cur - 2 + data) % 9 + 2; lat = data; end
            2: if (data != 0) begin nc = ((cur - 2 - data) % 9 + 9) % 9 + 2; lat = data; end
            default: begin
`ifdef COUNT_SEQ_BOUNCE_EN
                if (data != 0) begin
                    x   = (cur - 2 + data) % 16;
                    nc  = ((x <= 8) ? x : 16 - x) + 2;
                    lat = data;
                end
`else
                e = 1;
`endif
            end
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (prev_done && !reset) check("ready_after_done", cmd_ready, 1);
        prev_done = done;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                check("done_count", cnt_q, e.cnt);
                check("done_err", err, e.err);
                check("done_cycle", cyc, e.at);
            end
        end else if (err) begin
            check("err_without_done", err, 0);
        end
    end

    task automatic issue(input int op, input int data);
        int   w = 0;
        int   lat;
        exp_t e;
        while (!cmd_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        if (!cmd_ready) return;
        check("held_count", cnt_q, model_count);
        model(op, data, model_count, e.cnt, e.err, lat);
        e.at = cyc + 1 + lat;
        sb.push_back(e);
        model_count = e.cnt;
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_data  = data[3:0];
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 4'($urandom);
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((sb.size() != 0 || !cmd_ready) && w < 300) begin
            @(negedge clock);
            w++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_load", load, 1);
        check("rst_din", din, cnt_q);
        check("rst_up_down", up_down, 1);
        reset = 1'b0;
        @(negedge clock);

        issue(0, 7);  wait_idle(); check("load7", cnt_q, 7);
        issue(0, 8);  issue(1, 4); wait_idle(); check("up4_wrap", cnt_q, 3);
        issue(2, 3);  wait_idle();
        repeat (10) @(negedge clock);
        check("down3_held", cnt_q, 9);
        issue(0, 9);  issue(3, 5); wait_idle();
`ifdef COUNT_SEQ_BOUNCE_EN
        check("bounce5", cnt_q, 6);
`else
        check("bounce_illegal", cnt_q, 9);
`endif
        issue(0, 12); issue(1, 0); wait_idle();
        check("reject_hold", cnt_q, model_count);

        // Reset while the second step of UP 6 is pending.
        issue(0, 3); wait_idle();
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 4'd6;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", cmd_ready, 1);
        check("midrst_load", load, 1);
        @(negedge clock);
        reset = 1'b0;
        model_count = 4;
        repeat (5) @(negedge clock);
        check("midrst_count", cnt_q, 4);
        issue(1, 2); wait_idle();
        check("after_rst_up2", cnt_q, 6);

        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom % 4), int'($urandom % 16));
            repeat ($urandom % 3) @(negedge clock);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
